// File: rtl/score_keeper.sv
// score_keeper: game-side score tracker feeding the two-digit score display.
// Turns round-result strobes (start/pass/fail) into a score with streak bonus,
// keeps the session high score, and alternates final/high score on game over.
//
// Display load interface: number is registered together with change_score.
// change_score is high for exactly one cycle, and number already holds the new
// value in that same cycle. The display has no back-pressure, so the strobe is
// never held or repeated. A pulse therefore means "load number now".
module score_keeper #(
  parameter int MAX_SCORE   = 99,
  parameter int STREAK_LEN  = 5,
  parameter int BONUS       = 2,
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       pass,
  input  logic       fail,
  output logic [7:0] number,
  output logic       change_score,
  output logic       game_over,
  output logic       new_high,
  output logic [7:0] high_score
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int              CW            = $clog2(SHOW_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST      = CW'(SHOW_CYCLES - 1);
  localparam logic [8:0]      MAX9          = 9'(MAX_SCORE);
  localparam logic [8:0]      ADD_BONUS     = 9'(1 + BONUS);
  localparam logic [15:0]     STREAK_TARGET = 16'(STREAK_LEN);

  state_t        state;
  logic          start_prev;
  logic          pass_prev;
  logic          fail_prev;
  logic          ev_start;
  logic          ev_pass;
  logic          ev_fail;
  logic [7:0]    score;
  logic [15:0]   streak;
  logic          show_high;
  logic [CW-1:0] show_cnt;
  logic [15:0]   streak_next;
  logic [15:0]   streak_after;
  logic [8:0]    add;
  logic [8:0]    sum;
  logic [7:0]    score_after;

  // Rising-edge detection and the score/streak update a pass would cause.
  // The sum is kept 9 bits wide so a saturated score cannot wrap to zero.
  always_comb begin
    ev_start     = start & ~start_prev;
    ev_pass      = pass  & ~pass_prev;
    ev_fail      = fail  & ~fail_prev;
    streak_next  = streak + 16'd1;
    add          = 9'd1;
    streak_after = streak_next;
    if ((STREAK_LEN != 0) && (streak_next == STREAK_TARGET)) begin
      add          = ADD_BONUS;
      streak_after = '0;
    end
    sum         = {1'b0, score} + add;
    score_after = (sum > MAX9) ? MAX9[7:0] : sum[7:0];
  end

  // Game FSM with registered display outputs. A start edge wins in every
  // state, so it is handled ahead of the per-state behaviour.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      start_prev   <= 1'b1;
      pass_prev    <= 1'b1;
      fail_prev    <= 1'b1;
      score        <= '0;
      streak       <= '0;
      high_score   <= '0;
      number       <= '0;
      show_cnt     <= '0;
      show_high    <= 1'b0;
      change_score <= 1'b0;
      game_over    <= 1'b0;
      new_high     <= 1'b0;
    end else begin
      start_prev   <= start;
      pass_prev    <= pass;
      fail_prev    <= fail;
      change_score <= 1'b0;
      if (ev_start) begin
        state        <= PLAY;
        score        <= '0;
        streak       <= '0;
        number       <= '0;
        change_score <= 1'b1;
        game_over    <= 1'b0;
        new_high     <= 1'b0;
        show_high    <= 1'b0;
        show_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            number <= high_score;
          end
          PLAY: begin
            if (ev_fail) begin
              state        <= OVER;
              game_over    <= 1'b1;
              number       <= score;
              change_score <= 1'b1;
              show_cnt     <= '0;
              show_high    <= 1'b0;
              if (score > high_score) begin
                high_score <= score;
                new_high   <= 1'b1;
              end else begin
                new_high <= 1'b0;
              end
            end else if (ev_pass) begin
              score        <= score_after;
              streak       <= streak_after;
              number       <= score_after;
              change_score <= 1'b1;
            end
          end
          OVER: begin
            // The final score stays in score while the display alternates.
            if (show_cnt == CNT_LAST) begin
              show_cnt     <= '0;
              show_high    <= ~show_high;
              number       <= show_high ? score : high_score;
              change_score <= 1'b1;
            end else begin
              show_cnt <= show_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper. Two instances share the stimulus: dut_a has the
// streak bonus disabled, dut_b uses the default streak of 5 with bonus 2.
// Both alternate every 4 cycles in OVER.
module tb_score_keeper;

  logic       clock;
  logic       resetn;
  logic       start;
  logic       pass;
  logic       fail;

  logic [7:0] a_number;
  logic       a_change;
  logic       a_game_over;
  logic       a_new_high;
  logic [7:0] a_high;

  logic [7:0] b_number;
  logic       b_change;
  logic       b_game_over;
  logic       b_new_high;
  logic [7:0] b_high;

  int checks = 0;
  int errors = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  logic [7:0] exp_a;
  logic [7:0] exp_b;

  score_keeper #(
    .MAX_SCORE(99), .STREAK_LEN(0), .BONUS(2), .SHOW_CYCLES(4)
  ) dut_a (
    .clock(clock), .resetn(resetn), .start(start), .pass(pass), .fail(fail),
    .number(a_number), .change_score(a_change), .game_over(a_game_over),
    .new_high(a_new_high), .high_score(a_high)
  );

  score_keeper #(
    .MAX_SCORE(99), .STREAK_LEN(5), .BONUS(2), .SHOW_CYCLES(4)
  ) dut_b (
    .clock(clock), .resetn(resetn), .start(start), .pass(pass), .fail(fail),
    .number(b_number), .change_score(b_change), .game_over(b_game_over),
    .new_high(b_new_high), .high_score(b_high)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // scoreboard: every load strobe must match the oldest expected number
  always @(negedge clock) begin
    if (resetn === 1'b1 && a_change === 1'b1) begin
      pulses_a++;
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_pulse: number=%0d, required no pulse", a_number);
      end else begin
        exp_a = exp_a_q.pop_front();
        if (a_number !== exp_a) begin
          errors++;
          $display("FAIL a_number: got %0d, required %0d", a_number, exp_a);
        end
      end
    end
    if (resetn === 1'b1 && b_change === 1'b1) begin
      pulses_b++;
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_pulse: number=%0d, required no pulse", b_number);
      end else begin
        exp_b = exp_b_q.pop_front();
        if (b_number !== exp_b) begin
          errors++;
          $display("FAIL b_number: got %0d, required %0d", b_number, exp_b);
        end
      end
    end
  end

  // driver tasks
  task automatic apply_reset(input logic hold);
    resetn = 1'b0;
    start  = hold;
    pass   = hold;
    fail   = hold;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  // One-cycle input pulse; the event edge is the second posedge.
  task automatic drive(input logic s, input logic p, input logic f);
    @(posedge clock);
    #1;
    start = s;
    pass  = p;
    fail  = f;
    @(posedge clock);
    #1;
    start = 1'b0;
    pass  = 1'b0;
    fail  = 1'b0;
  endtask

  task automatic expect_num(input logic [7:0] ea, input logic [7:0] eb);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 20) begin
      @(posedge clock);
      #2;
      n++;
    end
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending a=%0d b=%0d, required 0 0", tag,
               exp_a_q.size(), exp_b_q.size());
      exp_a_q.delete();
      exp_b_q.delete();
    end
  endtask

  // tests
  task automatic test_reset();
    int pa;
    int pb;
    apply_reset(1'b1);
    pa = pulses_a;
    pb = pulses_b;
    repeat (6) @(posedge clock);
    #2;
    checks++;
    if (pulses_a !== pa || pulses_b !== pb) begin
      errors++;
      $display("FAIL reset_hold_pulses: got %0d/%0d, required 0", pulses_a - pa, pulses_b - pb);
    end
    checks++;
    if (a_number !== 8'd0 || b_number !== 8'd0) begin
      errors++;
      $display("FAIL reset_number: got %0d/%0d, required 0", a_number, b_number);
    end
    checks++;
    if (a_high !== 8'd0 || b_high !== 8'd0) begin
      errors++;
      $display("FAIL reset_high: got %0d/%0d, required 0", a_high, b_high);
    end
    checks++;
    if (a_game_over !== 1'b0 || a_new_high !== 1'b0 || a_change !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got go=%b nh=%b cs=%b, required 0 0 0",
               a_game_over, a_new_high, a_change);
    end
    // pass/fail edges in IDLE are ignored
    start = 1'b0;
    pass  = 1'b0;
    fail  = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (pulses_a !== pa || a_game_over !== 1'b0 || a_number !== 8'd0) begin
      errors++;
      $display("FAIL idle_ignore: got pulses=%0d go=%b number=%0d, required 0 0 0",
               pulses_a - pa, a_game_over, a_number);
    end
  endtask

  task automatic test_basic_game();
    apply_reset(1'b0);
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      expect_num(8'(k), 8'(k));
      drive(1'b0, 1'b1, 1'b0);
    end
    expect_num(8'd3, 8'd3);
    drive(1'b0, 1'b0, 1'b1);
    wait_drain("basic");
    checks++;
    if (a_game_over !== 1'b1 || a_new_high !== 1'b1 || a_high !== 8'd3) begin
      errors++;
      $display("FAIL basic_over: got go=%b nh=%b high=%0d, required 1 1 3",
               a_game_over, a_new_high, a_high);
    end
    checks++;
    if (b_game_over !== 1'b1 || b_new_high !== 1'b1 || b_high !== 8'd3) begin
      errors++;
      $display("FAIL basic_over_b: got go=%b nh=%b high=%0d, required 1 1 3",
               b_game_over, b_new_high, b_high);
    end
  endtask

  task automatic test_streak();
    logic [7:0] streak_seq[6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8};
    apply_reset(1'b0);
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      expect_num(8'(k + 1), streak_seq[k]);
      drive(1'b0, 1'b1, 1'b0);
    end
    expect_num(8'd6, 8'd8);
    drive(1'b0, 1'b0, 1'b1);
    wait_drain("streak");
    checks++;
    if (a_high !== 8'd6 || b_high !== 8'd8) begin
      errors++;
      $display("FAIL streak_high: got %0d/%0d, required 6/8", a_high, b_high);
    end
  endtask

  task automatic test_saturation();
    int sa;
    int sb;
    apply_reset(1'b0);
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 101; k++) begin
      sa = (k > 99) ? 99 : k;
      sb = k + 2 * (k / 5);
      if (sb > 99) sb = 99;
      expect_num(8'(sa), 8'(sb));
      drive(1'b0, 1'b1, 1'b0);
    end
    wait_drain("saturation");
    checks++;
    if (a_number !== 8'd99 || b_number !== 8'd99) begin
      errors++;
      $display("FAIL saturation_final: got %0d/%0d, required 99", a_number, b_number);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset(1'b0);
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0);
    expect_num(8'd1, 8'd1);
    drive(1'b0, 1'b1, 1'b0);
    expect_num(8'd2, 8'd2);
    drive(1'b0, 1'b1, 1'b0);
    // pass and fail together: fail wins, no increment
    expect_num(8'd2, 8'd2);
    drive(1'b0, 1'b1, 1'b1);
    wait_drain("pass_fail");
    checks++;
    if (a_game_over !== 1'b1 || a_high !== 8'd2 || a_number !== 8'd2) begin
      errors++;
      $display("FAIL pass_fail: got go=%b high=%0d number=%0d, required 1 2 2",
               a_game_over, a_high, a_number);
    end
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0);
    expect_num(8'd1, 8'd1);
    drive(1'b0, 1'b1, 1'b0);
    // start and fail together: restart wins, high score untouched
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b1);
    wait_drain("start_fail");
    checks++;
    if (a_game_over !== 1'b0 || a_high !== 8'd2 || a_number !== 8'd0) begin
      errors++;
      $display("FAIL start_fail: got go=%b high=%0d number=%0d, required 0 2 0",
               a_game_over, a_high, a_number);
    end
    expect_num(8'd1, 8'd1);
    drive(1'b0, 1'b1, 1'b0);
    wait_drain("start_fail_play");
  endtask

  task automatic test_over_alternation();
    logic [7:0] alt_a[4] = '{8'd5, 8'd2, 8'd5, 8'd2};
    logic [7:0] alt_b[4] = '{8'd7, 8'd2, 8'd7, 8'd2};
    apply_reset(1'b0);
    // first game sets the high score: 5 (a) / 7 (b)
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      expect_num(8'(k + 1), (k == 4) ? 8'd7 : 8'(k + 1));
      drive(1'b0, 1'b1, 1'b0);
    end
    expect_num(8'd5, 8'd7);
    drive(1'b0, 1'b0, 1'b1);
    wait_drain("alt_game1");
    // second game ends with 2
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0);
    expect_num(8'd1, 8'd1);
    drive(1'b0, 1'b1, 1'b0);
    expect_num(8'd2, 8'd2);
    drive(1'b0, 1'b1, 1'b0);
    expect_num(8'd2, 8'd2);
    for (int t = 0; t < 4; t++) expect_num(alt_a[t], alt_b[t]);
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (a_game_over !== 1'b1 || a_new_high !== 1'b0 || a_high !== 8'd5 || b_high !== 8'd7) begin
      errors++;
      $display("FAIL alt_over: got go=%b nh=%b high=%0d/%0d, required 1 0 5/7",
               a_game_over, a_new_high, a_high, b_high);
    end
    for (int t = 0; t < 4; t++) begin
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (a_change !== 1'b0 || b_change !== 1'b0) begin
        errors++;
        $display("FAIL alt_gap_%0d: got cs=%b/%b, required 0", t, a_change, b_change);
      end
      @(posedge clock);
      #1;
      checks++;
      if (a_change !== 1'b1 || b_change !== 1'b1 || a_number !== alt_a[t]) begin
        errors++;
        $display("FAIL alt_toggle_%0d: got cs=%b/%b number=%0d, required 1 1 %0d",
                 t, a_change, b_change, a_number, alt_a[t]);
      end
    end
    expect_num(8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0);
    wait_drain("alt_restart");
    checks++;
    if (a_number !== 8'd0 || a_game_over !== 1'b0 || a_new_high !== 1'b0 || a_high !== 8'd5) begin
      errors++;
      $display("FAIL alt_restart: got number=%0d go=%b nh=%b high=%0d, required 0 0 0 5",
               a_number, a_game_over, a_new_high, a_high);
    end
  endtask

  // sequence and final report
  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    pass   = 1'b0;
    fail   = 1'b0;
    test_reset();
    test_basic_game();
    test_streak();
    test_saturation();
    test_simultaneous();
    test_over_alternation();
    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
